// File: rtl/apb4_pkg.sv
// Shared constants for the APB4 N-slave bridge: FSM encodings, PPROT fields and a
// constant-evaluable clog2 used to size indices and counters.
package apb4_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  localparam logic [2:0] PPROT_PRIV   = 3'b001;
  localparam logic [2:0] PPROT_NONSEC = 3'b010;
  localparam logic [2:0] PPROT_INSTR  = 3'b100;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/apb4_addr_decode.sv
// Combinational region decoder: slave i owns [BASE_ADDR + i<<REGION_BITS, +1<<REGION_BITS).
module apb4_addr_decode
  import apb4_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_SLAVES  = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    REGION_BITS = 12,
  localparam int                   IDX_W       = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [IDX_W-1:0]      idx_o
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] region;

  // Compare the region number rather than an end address so the top of the map cannot overflow.
  always_comb begin
    offset = addr_i - BASE_ADDR;
    region = offset >> REGION_BITS;
    hit_o  = (addr_i >= BASE_ADDR) && (region < ADDR_WIDTH'(NUM_SLAVES));
    idx_o  = region[IDX_W-1:0];
  end

endmodule

// File: rtl/apb4_nslave_bridge.sv
// APB4 requester with built-in N-way decode: one command in flight, SETUP/ACCESS on the
// selected PSEL, and a held response carrying slave, decode or timeout error causes.
module apb4_nslave_bridge
  import apb4_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_SLAVES  = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    REGION_BITS = 12,
  parameter int                    TIMEOUT     = 256,
  localparam int                   STRB_WIDTH  = DATA_WIDTH / 8,
  localparam int                   IDX_W       = (NUM_SLAVES > 1) ? clog2(NUM_SLAVES) : 1,
  localparam int                   TO_W_RAW    = clog2(TIMEOUT + 1),
  localparam int                   TO_W        = (TO_W_RAW > 0) ? TO_W_RAW : 1
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             CMD_VALID,
  output logic                             CMD_READY,
  input  logic                             CMD_WRITE,
  input  logic [ADDR_WIDTH-1:0]            CMD_ADDR,
  input  logic [DATA_WIDTH-1:0]            CMD_WDATA,
  input  logic [STRB_WIDTH-1:0]            CMD_STRB,
  input  logic [2:0]                       CMD_PROT,
  output logic                             RSP_VALID,
  input  logic                             RSP_READY,
  output logic [DATA_WIDTH-1:0]            RSP_RDATA,
  output logic                             RSP_SLVERR,
  output logic                             RSP_DECERR,
  output logic                             RSP_TIMEOUT,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_WIDTH-1:0]            PSTRB,
  output logic [2:0]                       PPROT,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t                  state_q,  state_d;
  logic                    live_q,   live_d;
  logic [ADDR_WIDTH-1:0]   addr_q,   addr_d;
  logic                    write_q,  write_d;
  logic [DATA_WIDTH-1:0]   wdata_q,  wdata_d;
  logic [STRB_WIDTH-1:0]   strb_q,   strb_d;
  logic [2:0]              prot_q,   prot_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;
  logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q,  rdata_d;
  logic                    slverr_q, slverr_d;
  logic                    decerr_q, decerr_d;
  logic                    tout_q,   tout_d;

  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic                    sel_ready;
  logic                    sel_err;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic [NUM_SLAVES-1:0]   psel;

  apb4_addr_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_decode (
    .addr_i (CMD_ADDR),
    .hit_o  (dec_hit),
    .idx_o  (dec_idx)
  );

  assign sel_ready = PREADY[idx_q];
  assign sel_err   = PSLVERR[idx_q];
  assign sel_rdata = PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];

  // live_q keeps CMD_READY low while reset is asserted and rises the cycle after release.
  always_comb begin
    state_d  = state_q;
    live_d   = 1'b1;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prot_d   = prot_q;
    idx_d    = idx_q;
    to_cnt_d = to_cnt_q;
    rdata_d  = rdata_q;
    slverr_d = slverr_q;
    decerr_d = decerr_q;
    tout_d   = tout_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID && live_q) begin
          addr_d  = CMD_ADDR;
          write_d = CMD_WRITE;
          wdata_d = CMD_WDATA;
          strb_d  = CMD_STRB;
          prot_d  = CMD_PROT;
          idx_d   = dec_idx;
          if (dec_hit) begin
            state_d = ST_SETUP;
          end else begin
            state_d  = ST_RESP;
            rdata_d  = '0;
            slverr_d = 1'b1;
            decerr_d = 1'b1;
            tout_d   = 1'b0;
          end
        end
      end
      ST_SETUP: begin
        state_d  = ST_ACCESS;
        to_cnt_d = '0;
      end
      ST_ACCESS: begin
        if (sel_ready) begin
          state_d  = ST_RESP;
          rdata_d  = write_q ? '0 : sel_rdata;
          slverr_d = sel_err;
          decerr_d = 1'b0;
          tout_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          state_d  = ST_RESP;
          rdata_d  = '0;
          slverr_d = 1'b1;
          decerr_d = 1'b0;
          tout_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: begin
        if (RSP_READY) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    psel = '0;
    if ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) psel[idx_q] = 1'b1;
  end

  assign CMD_READY   = live_q && (state_q == ST_IDLE);
  assign RSP_VALID   = (state_q == ST_RESP);
  assign RSP_RDATA   = rdata_q;
  assign RSP_SLVERR  = slverr_q;
  assign RSP_DECERR  = decerr_q;
  assign RSP_TIMEOUT = tout_q;
  assign PADDR       = addr_q;
  assign PWRITE      = write_q;
  assign PWDATA      = wdata_q;
  assign PSTRB       = write_q ? strb_q : '0;
  assign PPROT       = prot_q;
  assign PSEL        = psel;
  assign PENABLE     = (state_q == ST_ACCESS);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= ST_IDLE;
      live_q   <= 1'b0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prot_q   <= '0;
      idx_q    <= '0;
      to_cnt_q <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
      decerr_q <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= live_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prot_q   <= prot_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
      decerr_q <= decerr_d;
      tout_q   <= tout_d;
    end
  end

endmodule
